layer_mem_arbiter: RTL and testbench

LAYER_MEM_ARBITER -- requirements
Module: layer_mem_arbiter

---
 rtl/layer_mem_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_layer_mem_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_mem_arbiter.sv
// Three-requester arbiter for the layer memory: round-robin with burst lock.
// Grant is combinational; memory strobes registered one edge later, read data returned two edges after acceptance.
module layer_mem_arbiter #(
  parameter int AW       = 12,
  parameter int DW       = 20,
  parameter int LOCK_MAX = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [2:0]      req_valid,
  input  logic [2:0]      req_we,
  input  logic [2:0]      req_lock,
  input  logic [8:0]      req_sel,
  input  logic [3*AW-1:0] req_addr,
  input  logic [3*DW-1:0] req_wdata,
  output logic [2:0]      req_ready,
  output logic [2:0]      rsp_valid,
  output logic [DW-1:0]   rsp_data,
  output logic            cwr,
  output logic [AW-1:0]   caddr_wr,
  output logic [DW-1:0]   cdata_wr,
  output logic            crd,
  output logic [AW-1:0]   caddr_rd,
  input  logic [DW-1:0]   cdata_rd,
  output logic [2:0]      csel
);

  typedef enum logic {ARB = 1'b0, LOCK = 1'b1} state_e;

  localparam logic [7:0] LOCK_MAX_C = 8'(LOCK_MAX);

  function automatic logic [1:0] nxt_idx(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  state_e      state_q, state_d;
  logic [1:0]  owner_q, owner_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [7:0]  lock_cnt_q, lock_cnt_d;

  logic        gnt_vld;
  logic [1:0]  gnt_idx;
  logic [1:0]  cand;
  logic [7:0]  cnt_inc;

  logic          we_g;
  logic [2:0]    sel_g;
  logic [AW-1:0] addr_g;
  logic [DW-1:0] wdata_g;

  logic          cwr_q, cwr_d, crd_q, crd_d;
  logic [AW-1:0] caddr_wr_q, caddr_wr_d, caddr_rd_q, caddr_rd_d;
  logic [DW-1:0] cdata_wr_q, cdata_wr_d;
  logic [2:0]    csel_q, csel_d;
  logic [2:0]    rd_pend_q, rd_pend_d;
  logic [2:0]    rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ARB;
      owner_q    <= 2'd0;
      ptr_q      <= 2'd0;
      lock_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    lock_cnt_d = lock_cnt_q;
    cnt_inc    = lock_cnt_q + 8'd1;
    case (state_q)
      ARB: begin
        if (gnt_vld) begin
          if (req_lock[gnt_idx]) begin
            state_d    = LOCK;
            owner_d    = gnt_idx;
            lock_cnt_d = 8'd1;
          end else begin
            ptr_d = nxt_idx(gnt_idx);
          end
        end
      end
      default: begin
        // Reaching the cap releases the lock even if the owner still asks for it.
        if ((gnt_vld && (!req_lock[owner_q] || cnt_inc == LOCK_MAX_C)) ||
            (!gnt_vld && !req_lock[owner_q])) begin
          state_d    = ARB;
          ptr_d      = nxt_idx(owner_q);
          lock_cnt_d = 8'd0;
        end else if (gnt_vld) begin
          lock_cnt_d = cnt_inc;
        end
      end
    endcase
  end

  always_comb begin
    gnt_vld   = 1'b0;
    gnt_idx   = 2'd0;
    cand      = ptr_q;
    req_ready = 3'b000;
    if (reset) begin
      if (state_q == ARB) begin
        for (int k = 0; k < 3; k++) begin
          if (!gnt_vld && req_valid[cand]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand;
          end
          cand = nxt_idx(cand);
        end
      end else if (req_valid[owner_q]) begin
        gnt_vld = 1'b1;
        gnt_idx = owner_q;
      end
      req_ready = gnt_vld ? (3'b001 << gnt_idx) : 3'b000;
    end
  end

  always_comb begin
    we_g    = 1'b0;
    sel_g   = 3'b000;
    addr_g  = '0;
    wdata_g = '0;
    for (int k = 0; k < 3; k++) begin
      if (gnt_idx == 2'(k)) begin
        we_g    = req_we[k];
        sel_g   = req_sel[k*3 +: 3];
        addr_g  = req_addr[k*AW +: AW];
        wdata_g = req_wdata[k*DW +: DW];
      end
    end
  end

  always_comb begin
    cwr_d       = gnt_vld & we_g;
    crd_d       = gnt_vld & ~we_g;
    caddr_wr_d  = cwr_d ? addr_g : caddr_wr_q;
    cdata_wr_d  = cwr_d ? wdata_g : cdata_wr_q;
    caddr_rd_d  = crd_d ? addr_g : caddr_rd_q;
    csel_d      = gnt_vld ? sel_g : csel_q;
    rd_pend_d   = crd_d ? req_ready : 3'b000;
    rsp_valid_d = rd_pend_q;
    rsp_data_d  = (|rd_pend_q) ? cdata_rd : rsp_data_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cwr_q       <= 1'b0;
      crd_q       <= 1'b0;
      caddr_wr_q  <= '0;
      cdata_wr_q  <= '0;
      caddr_rd_q  <= '0;
      csel_q      <= 3'b000;
      rd_pend_q   <= 3'b000;
      rsp_valid_q <= 3'b000;
      rsp_data_q  <= '0;
    end else begin
      cwr_q       <= cwr_d;
      crd_q       <= crd_d;
      caddr_wr_q  <= caddr_wr_d;
      cdata_wr_q  <= cdata_wr_d;
      caddr_rd_q  <= caddr_rd_d;
      csel_q      <= csel_d;
      rd_pend_q   <= rd_pend_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign cwr       = cwr_q;
  assign crd       = crd_q;
  assign caddr_wr  = caddr_wr_q;
  assign cdata_wr  = cdata_wr_q;
  assign caddr_rd  = caddr_rd_q;
  assign csel      = csel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_layer_mem_arbiter.sv
// Bench for layer_mem_arbiter: queued requester transactions, memory model,
// read-response scoreboard and a grant log checked against expected orderings.
`timescale 1ns/1ps
module tb_layer_mem_arbiter;
  localparam int AW = 12;
  localparam int DW = 20;

  logic            clk = 1'b0;
  logic            reset;
  logic [2:0]      req_valid, req_we, req_lock;
  logic [8:0]      req_sel;
  logic [3*AW-1:0] req_addr;
  logic [3*DW-1:0] req_wdata;
  logic [2:0]      req_ready, rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            cwr, crd;
  logic [AW-1:0]   caddr_wr, caddr_rd;
  logic [DW-1:0]   cdata_wr, cdata_rd;
  logic [2:0]      csel;

  layer_mem_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_lock(req_lock),
    .req_sel(req_sel), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
    .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .csel(csel)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            gap;
    logic          we;
    logic          lock;
    logic [2:0]    sel;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  typedef struct {
    logic [DW-1:0] d;
    int            cyc;
  } exp_t;

  txn_t txq[3][$];
  exp_t sbq[3][$];
  int   glog_idx[$];
  int   glog_cyc[$];

  logic [DW-1:0] mem[4096];
  logic [DW-1:0] shadow[4096];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int cwr_cnt = 0;
  int crd_cnt = 0;
  logic [2:0] acc = 3'b000;

  logic          e_cwr, e_crd;
  logic [AW-1:0] e_caddr_wr, e_caddr_rd;
  logic [DW-1:0] e_cdata_wr;
  logic [2:0]    e_csel;
  logic [AW-1:0] lw_addr;
  logic [DW-1:0] lw_data;
  logic [2:0]    lw_sel;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic txn_t mk(input int gap, input logic we, input logic lock,
                              input logic [2:0] sel, input logic [AW-1:0] addr,
                              input logic [DW-1:0] wd);
    txn_t t;
    t.gap = gap; t.we = we; t.lock = lock; t.sel = sel; t.addr = addr; t.wdata = wd;
    return t;
  endfunction

  // Memory: synchronous write from the DUT strobe, asynchronous read.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cwr) mem[caddr_wr] <= cdata_wr;
  end
  assign cdata_rd = mem[caddr_rd];

  // Requester driver: retire on acceptance, then present the next transaction.
  initial begin
    txn_t t;
    req_valid = 3'b000; req_we = 3'b000; req_lock = 3'b000;
    req_sel = '0; req_addr = '0; req_wdata = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        if (acc[i] && txq[i].size() > 0) void'(txq[i].pop_front());
        if (txq[i].size() > 0) begin
          t = txq[i][0];
          if (t.gap > 0) begin
            t.gap--;
            txq[i][0] = t;
            req_valid[i] = 1'b0;
            req_lock[i]  = t.lock;
          end else begin
            req_valid[i] = 1'b1;
            req_we[i]    = t.we;
            req_lock[i]  = t.lock;
            req_sel[i*3 +: 3]    = t.sel;
            req_addr[i*AW +: AW] = t.addr;
            req_wdata[i*DW +: DW] = t.wdata;
          end
        end else begin
          req_valid[i] = 1'b0;
          req_lock[i]  = 1'b0;
        end
      end
    end
  end

  // Monitor: memory-side expectations, response scoreboard, grant log.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      e_cwr = 1'b0; e_crd = 1'b0; e_caddr_wr = '0; e_caddr_rd = '0;
      e_cdata_wr = '0; e_csel = 3'b000;
      for (int i = 0; i < 3; i++) sbq[i].delete();
      check_eq("rdy_in_reset", {29'd0, req_ready}, 32'd0);
    end
    check_eq("cwr", {31'd0, cwr}, {31'd0, e_cwr});
    check_eq("crd", {31'd0, crd}, {31'd0, e_crd});
    check_eq("caddr_wr", {20'd0, caddr_wr}, {20'd0, e_caddr_wr});
    check_eq("caddr_rd", {20'd0, caddr_rd}, {20'd0, e_caddr_rd});
    check_eq("cdata_wr", {12'd0, cdata_wr}, {12'd0, e_cdata_wr});
    check_eq("csel", {29'd0, csel}, {29'd0, e_csel});
    check_eq("rdy_onehot", {31'd0, $onehot0(req_ready)}, 32'd1);
    check_eq("rdy_no_vld", {29'd0, req_ready & ~req_valid}, 32'd0);
    check_eq("rsp_onehot", {31'd0, $onehot0(rsp_valid)}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      if (rsp_valid[i]) begin
        if (sbq[i].size() == 0) begin
          check_eq("rsp_unexpected", {29'd0, rsp_valid}, 32'd0);
        end else begin
          e = sbq[i].pop_front();
          check_eq("rsp_data", {12'd0, rsp_data}, {12'd0, e.d});
          check_eq("rsp_latency", cyc, e.cyc);
        end
      end
    end
    if (cwr) begin
      cwr_cnt++;
      lw_addr = caddr_wr; lw_data = cdata_wr; lw_sel = csel;
    end
    if (crd) crd_cnt++;

    acc = req_valid & req_ready;
    e_cwr = 1'b0;
    e_crd = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (acc[i]) begin
        glog_idx.push_back(i);
        glog_cyc.push_back(cyc);
        e_csel = req_sel[i*3 +: 3];
        if (req_we[i]) begin
          e_cwr = 1'b1;
          e_caddr_wr = req_addr[i*AW +: AW];
          e_cdata_wr = req_wdata[i*DW +: DW];
          shadow[req_addr[i*AW +: AW]] = req_wdata[i*DW +: DW];
        end else begin
          e_crd = 1'b1;
          e_caddr_rd = req_addr[i*AW +: AW];
          e.d = shadow[req_addr[i*AW +: AW]];
          e.cyc = cyc + 2;
          sbq[i].push_back(e);
        end
      end
    end
  end

  function automatic int pending();
    int n;
    n = 0;
    for (int i = 0; i < 3; i++) n += txq[i].size() + sbq[i].size();
    return n;
  endfunction

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (pending() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    check_eq(tag, {31'd0, n < 2000}, 32'd1);
    repeat (2) @(posedge clk);
    #2;
  endtask

  initial begin
    int base;
    int n;
    int exp20[4];
    int exp23_off[4];
    int exp23_idx[4];
    exp20 = '{0, 1, 2, 0};
    exp23_off = '{0, 4, 5, 6};
    exp23_idx = '{0, 0, 0, 1};
    for (int a = 0; a < 4096; a++) begin
      mem[a] = DW'(a * 37 + 5) ^ 20'h5A5A5;
      shadow[a] = mem[a];
    end
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_eq("rst_cwr", {31'd0, cwr}, 32'd0);
    check_eq("rst_crd", {31'd0, crd}, 32'd0);
    check_eq("rst_csel", {29'd0, csel}, 32'd0);
    check_eq("rst_caddr_wr", {20'd0, caddr_wr}, 32'd0);
    check_eq("rst_caddr_rd", {20'd0, caddr_rd}, 32'd0);
    check_eq("rst_cdata_wr", {12'd0, cdata_wr}, 32'd0);
    check_eq("rst_rsp_valid", {29'd0, rsp_valid}, 32'd0);
    check_eq("rst_rsp_data", {12'd0, rsp_data}, 32'd0);
    check_eq("rst_req_ready", {29'd0, req_ready}, 32'd0);
    reset = 1'b1;

    // Round-robin over three continuously valid readers.
    base = glog_idx.size();
    txq[0].push_back(mk(0, 1'b0, 1'b0, 3'b001, 12'h010, '0));
    txq[1].push_back(mk(0, 1'b0, 1'b0, 3'b010, 12'h020, '0));
    txq[2].push_back(mk(0, 1'b0, 1'b0, 3'b100, 12'h030, '0));
    txq[0].push_back(mk(0, 1'b0, 1'b0, 3'b001, 12'h040, '0));
    wait_idle("idle_rr");
    n = glog_idx.size() - base;
    check_eq("rr_count", n, 4);
    if (n >= 4) begin
      for (int k = 0; k < 4; k++) begin
        check_eq("rr_owner", glog_idx[base+k], exp20[k]);
        check_eq("rr_cycle", glog_cyc[base+k] - glog_cyc[base], k);
      end
    end

    // Single write from requester 1.
    cwr_cnt = 0;
    crd_cnt = 0;
    txq[1].push_back(mk(0, 1'b1, 1'b0, 3'b010, 12'h7FF, 20'hABCDE));
    wait_idle("idle_wr");
    check_eq("wr_pulses", cwr_cnt, 1);
    check_eq("wr_no_rd", crd_cnt, 0);
    check_eq("wr_addr", {20'd0, lw_addr}, 32'h7FF);
    check_eq("wr_data", {12'd0, lw_data}, 32'hABCDE);
    check_eq("wr_sel", {29'd0, lw_sel}, 32'd2);
    check_eq("wr_mem", {12'd0, mem[12'h7FF]}, 32'hABCDE);

    // Locked burst of 20 from requester 2 capped at 16 while requester 0 waits.
    base = glog_idx.size();
    for (int k = 0; k < 20; k++)
      txq[2].push_back(mk(0, 1'b0, 1'b1, 3'b100, 12'(12'h100 + k), '0));
    txq[0].push_back(mk(0, 1'b0, 1'b0, 3'b001, 12'h200, '0));
    wait_idle("idle_lock");
    n = glog_idx.size() - base;
    check_eq("lock_count", n, 21);
    if (n >= 21) begin
      for (int k = 0; k < 21; k++) begin
        check_eq("lock_owner", glog_idx[base+k], (k == 16) ? 0 : 2);
        check_eq("lock_cycle", glog_cyc[base+k] - glog_cyc[base], k);
      end
    end

    // Locked owner drops valid for 3 cycles while keeping lock; r1 must wait.
    base = glog_idx.size();
    txq[0].push_back(mk(0, 1'b0, 1'b1, 3'b001, 12'h300, '0));
    txq[0].push_back(mk(3, 1'b0, 1'b1, 3'b001, 12'h301, '0));
    txq[0].push_back(mk(0, 1'b0, 1'b0, 3'b001, 12'h302, '0));
    txq[1].push_back(mk(0, 1'b0, 1'b0, 3'b010, 12'h310, '0));
    wait_idle("idle_gap");
    n = glog_idx.size() - base;
    check_eq("gap_count", n, 4);
    if (n >= 4) begin
      for (int k = 0; k < 4; k++) begin
        check_eq("gap_owner", glog_idx[base+k], exp23_idx[k]);
        check_eq("gap_cycle", glog_cyc[base+k] - glog_cyc[base], exp23_off[k]);
      end
    end

    // Reset lands while a read is in flight.
    base = glog_idx.size();
    txq[0].push_back(mk(0, 1'b0, 1'b0, 3'b001, 12'h050, '0));
    n = 0;
    while (glog_idx.size() == base && n < 50) begin
      @(posedge clk);
      n++;
    end
    check_eq("mid_grant_seen", {31'd0, glog_idx.size() > base}, 32'd1);
    #3 reset = 1'b0;
    #1;
    check_eq("mid_crd", {31'd0, crd}, 32'd0);
    check_eq("mid_caddr_rd", {20'd0, caddr_rd}, 32'd0);
    check_eq("mid_csel", {29'd0, csel}, 32'd0);
    check_eq("mid_rsp_valid", {29'd0, rsp_valid}, 32'd0);
    txq[0].push_back(mk(0, 1'b0, 1'b0, 3'b001, 12'h060, '0));
    txq[1].push_back(mk(0, 1'b0, 1'b0, 3'b010, 12'h061, '0));
    txq[2].push_back(mk(0, 1'b0, 1'b0, 3'b100, 12'h062, '0));
    repeat (3) @(posedge clk);
    #2;
    check_eq("mid_rdy_held", {29'd0, req_ready}, 32'd0);
    base = glog_idx.size();
    reset = 1'b1;
    wait_idle("idle_rst");
    n = glog_idx.size() - base;
    check_eq("post_rst_count", n, 3);
    if (n >= 1) check_eq("post_rst_first", glog_idx[base], 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
